// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
// Key index is col*4 + row; KEY_NONE marks a scan in which no key was down.
package keypad_pkg;

    localparam int unsigned NUM_ROWS = 4;
    localparam int unsigned NUM_COLS = 4;
    localparam int unsigned NUM_KEYS = NUM_ROWS * NUM_COLS;

    typedef enum logic [1:0] {
        StScan,
        StConfirm,
        StPressed,
        StRelease
    } key_state_e;

    localparam logic [4:0] KEY_NONE = 5'h10;

    // Game-control buttons as wired on the front panel.
    localparam logic [3:0] KEY_UP     = 4'd1;
    localparam logic [3:0] KEY_START  = 4'd3;
    localparam logic [3:0] KEY_LEFT   = 4'd4;
    localparam logic [3:0] KEY_RIGHT  = 4'd6;
    localparam logic [3:0] KEY_DOWN   = 4'd9;
    localparam logic [3:0] KEY_SELECT = 4'd12;

    // Lowest pressed index wins; KEY_NONE when nothing is down.
    function automatic logic [4:0] lowest_key(input logic [NUM_KEYS-1:0] keys);
        logic [4:0] idx;
        idx = KEY_NONE;
        for (int i = int'(NUM_KEYS) - 1; i >= 0; i--) begin
            if (keys[i]) idx = 5'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for asynchronous level inputs.
// Resets to RESET_VALUE so idle pulled-up lines never look active.
module keypad_sync #(
    parameter int unsigned      WIDTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= RESET_VALUE;
            sync_q <= RESET_VALUE;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
        end
    end

    assign dout = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column strobing, debounce and one event per press.
// Define KEYPAD_REPEAT_EN to add auto-repeat events while a key is held.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter logic [15:0] SCAN_DIV       = 16'd50000,
    parameter int unsigned DEBOUNCE_SCANS = 4,
    parameter int unsigned REPEAT_SCANS   = 40
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_ROWS-1:0] row_n,
    output logic [NUM_COLS-1:0] col_n,
    output logic [3:0]          key_code,
    output logic                key_valid,
    input  logic                key_ready,
    output logic                key_held,
    output logic                overflow
);

    if (SCAN_DIV < 16'd4 || DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15 || REPEAT_SCANS < 1)
    begin : gen_bad_param
        $error("keypad_scanner: parameter out of range");
    end

    localparam logic [15:0] DWELL_LAST = SCAN_DIV - 16'd1;
    localparam logic [3:0]  DEB_TARGET = 4'(DEBOUNCE_SCANS);

    logic [NUM_ROWS-1:0] row_sync_n;

    keypad_sync #(
        .WIDTH       (NUM_ROWS),
        .RESET_VALUE ('1)
    ) u_row_sync (
        .clk   (clk),
        .reset (reset),
        .din   (row_n),
        .dout  (row_sync_n)
    );

    // Column strobing; keys_q holds columns 0..2, column 3 is taken live at scan end.
    logic [15:0] dwell_q;
    logic [1:0]  col_q;
    logic [11:0] keys_q;
    logic        dwell_last;
    logic        scan_end;
    logic [4:0]  scan_result;

    assign dwell_last  = (dwell_q == DWELL_LAST);
    assign scan_end    = dwell_last && (col_q == 2'd3);
    assign scan_result = lowest_key({~row_sync_n, keys_q});
    assign col_n       = ~(4'b0001 << col_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dwell_q <= '0;
            col_q   <= '0;
            keys_q  <= '0;
        end else if (dwell_last) begin
            dwell_q <= '0;
            col_q   <= col_q + 2'd1;
            unique case (col_q)
                2'd0:    keys_q[3:0]  <= ~row_sync_n;
                2'd1:    keys_q[7:4]  <= ~row_sync_n;
                2'd2:    keys_q[11:8] <= ~row_sync_n;
                default: ;
            endcase
        end else begin
            dwell_q <= dwell_q + 16'd1;
        end
    end

    // Debounce FSM, advanced once per scan end.
    key_state_e state_q, state_d;
    logic [3:0] cand_q, cand_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] cnt_inc;
    logic       emit;

`ifdef KEYPAD_REPEAT_EN
    localparam logic [15:0] REPEAT_FIRST = 16'(REPEAT_SCANS);
    localparam logic [15:0] REPEAT_NEXT  = (REPEAT_SCANS / 4 == 0) ? 16'd1 : 16'(REPEAT_SCANS / 4);

    logic [15:0] hold_q, hold_d;
    logic [15:0] hold_inc;
    logic        rep_q, rep_d;
`endif

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        cnt_inc = cnt_q + 4'd1;
        emit    = 1'b0;
        if (scan_end) begin
            unique case (state_q)
                StScan: begin
                    if (scan_result != KEY_NONE) begin
                        cand_d = scan_result[3:0];
                        if (DEB_TARGET == 4'd1) begin
                            state_d = StPressed;
                            cnt_d   = '0;
                            emit    = 1'b1;
                        end else begin
                            state_d = StConfirm;
                            cnt_d   = 4'd1;
                        end
                    end
                end
                StConfirm: begin
                    if (scan_result == {1'b0, cand_q}) begin
                        if (cnt_inc == DEB_TARGET) begin
                            state_d = StPressed;
                            cnt_d   = '0;
                            emit    = 1'b1;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        state_d = StScan;
                        cnt_d   = '0;
                    end
                end
                StPressed: begin
                    if (scan_result == KEY_NONE) begin
                        state_d = (DEB_TARGET == 4'd1) ? StScan : StRelease;
                        cnt_d   = (DEB_TARGET == 4'd1) ? 4'd0 : 4'd1;
                    end
                end
                StRelease: begin
                    if (scan_result == KEY_NONE) begin
                        if (cnt_inc == DEB_TARGET) begin
                            state_d = StScan;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else if (scan_result[3:0] == cand_q) begin
                        state_d = StPressed;
                        cnt_d   = '0;
                    end else begin
                        // Another key only restarts the release streak.
                        cnt_d = '0;
                    end
                end
                default: state_d = StScan;
            endcase
        end

`ifdef KEYPAD_REPEAT_EN
        hold_d   = hold_q;
        rep_d    = rep_q;
        hold_inc = hold_q + 16'd1;
        if (state_d != StPressed) begin
            hold_d = '0;
            rep_d  = 1'b0;
        end else if (scan_end && state_q == StPressed) begin
            if (hold_inc == (rep_q ? REPEAT_NEXT : REPEAT_FIRST)) begin
                emit   = 1'b1;
                hold_d = '0;
                rep_d  = 1'b1;
            end else begin
                hold_d = hold_inc;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StScan;
            cand_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef KEYPAD_REPEAT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_q <= '0;
            rep_q  <= 1'b0;
        end else begin
            hold_q <= hold_d;
            rep_q  <= rep_d;
        end
    end
`endif

    // Event register: an unaccepted event blocks newer ones, which set overflow.
    logic [3:0] key_code_q;
    logic       key_valid_q;
    logic       overflow_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            if (key_valid_q && key_ready) key_valid_q <= 1'b0;
            if (emit) begin
                if (key_valid_q && !key_ready) begin
                    overflow_q <= 1'b1;
                end else begin
                    key_valid_q <= 1'b1;
                    key_code_q  <= cand_d;
                end
            end
        end
    end

    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign overflow  = overflow_q;
    assign key_held  = (state_q == StPressed) || (state_q == StRelease);

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad matrix model plus a scan-level debounce/event model.
// Key masks change only at scan boundaries, so each scan sees one stable key set.
module tb_keypad_scanner;

    localparam logic [15:0] SCAN_DIV = 16'd8;
    localparam int          DEB      = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_ready = 1'b0;
    logic        key_held;
    logic        overflow;
    logic [15:0] mask = '0;

    int n_checks = 0;
    int n_fail   = 0;

    keypad_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEB),
        .REPEAT_SCANS   (40)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .row_n     (row_n),
        .col_n     (col_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_held  (key_held),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Pressed key at (c, r) shorts column c to row r.
    always_comb begin
        row_n = 4'hF;
        for (int c = 0; c < 4; c++) begin
            if (!col_n[c]) begin
                for (int r = 0; r < 4; r++) begin
                    if (mask[c*4+r]) row_n[r] = 1'b0;
                end
            end
        end
    end

    int cyc = 0;
    bit mon_en = 0;
    int valid_cycles, held_cycles, ovf_cycles, first_valid;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_en) begin
            if (key_valid) valid_cycles++;
            if (key_held) held_cycles++;
            if (overflow) ovf_cycles++;
            if (key_valid && first_valid < 0) first_valid = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state, one step per full scan.
    bit m_held, m_pend, m_ovf;
    int m_cand, m_run, m_rel, m_code;

    task automatic model_reset();
        m_held = 0; m_pend = 0; m_ovf = 0;
        m_cand = 0; m_run = 0; m_rel = 0; m_code = 0;
    endtask

    function automatic int lowest(input logic [15:0] m);
        for (int i = 0; i < 16; i++) if (m[i]) return i;
        return -1;
    endfunction

    task automatic model_scan_end(input int res);
        bit fire = 0;
        if (!m_held) begin
            if (res < 0 || (m_run > 0 && res != m_cand)) begin
                m_run = 0;
            end else begin
                if (m_run == 0) m_cand = res;
                m_run++;
                if (m_run == DEB) begin
                    m_held = 1; m_run = 0; m_rel = 0; fire = 1;
                end
            end
        end else if (res < 0) begin
            m_rel++;
            if (m_rel == DEB) begin
                m_held = 0; m_rel = 0;
            end
        end else begin
            m_rel = 0;
        end
        if (fire) begin
            if (m_pend) m_ovf = 1;
            else begin
                m_pend = 1; m_code = m_cand;
            end
        end
    endtask

    // One full scan with key set m; rdy drives key_ready, pulse limits it to the first cycle.
    task automatic do_scan(input logic [15:0] m, input bit rdy, input bit pulse);
        logic [3:0] exp_col;
        mask = m;
        key_ready = rdy;
        if (m_pend && rdy) m_pend = 0;
        for (int c = 0; c < 4; c++) begin
            exp_col = ~(4'b0001 << c);
            check("col_n", col_n, exp_col);
            for (int k = 0; k < 8; k++) begin
                @(posedge clk);
                @(negedge clk);
                if (pulse && c == 0 && k == 0) begin
                    key_ready = 1'b0;
                    check("valid_after_pulse", key_valid, m_pend);
                end
            end
        end
        model_scan_end(lowest(m));
        check("key_valid", key_valid, m_pend);
        if (m_pend) check("key_code", key_code, m_code);
        check("key_held", key_held, m_held);
        check("overflow", overflow, m_ovf);
    endtask

    task automatic mon_start();
        valid_cycles = 0; held_cycles = 0; ovf_cycles = 0; first_valid = -1;
        mon_en = 1;
    endtask

    localparam logic [15:0] K3  = 16'h0008;
    localparam logic [15:0] K5  = 16'h0020;
    localparam logic [15:0] K6  = 16'h0040;
    localparam logic [15:0] K9  = 16'h0200;
    localparam logic [15:0] K12 = 16'h1000;

    initial begin
        int press_cyc;
        logic [15:0] m;
        int r;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_col_n", col_n, 4'b1110);
        check("rst_key_code", key_code, 4'd0);
        check("rst_key_valid", key_valid, 1'b0);
        check("rst_key_held", key_held, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        reset = 1'b1;

        // Idle: column walk only, no activity for 32 scans.
        mon_start();
        for (int i = 0; i < 32; i++) do_scan('0, 1'b1, 1'b0);
        mon_en = 0;
        check("idle_valid_cycles", valid_cycles, 0);
        check("idle_held_cycles", held_cycles, 0);
        check("idle_ovf_cycles", ovf_cycles, 0);

        // Single press of key 6 with the consumer always ready.
        mon_start();
        press_cyc = cyc;
        for (int i = 0; i < 3; i++) do_scan(K6, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) do_scan('0, 1'b1, 1'b0);
        mon_en = 0;
        check("press_valid_cycles", valid_cycles, 1);
        check("press_latency_ok",
              (first_valid > press_cyc) && (first_valid - press_cyc <= 131), 1'b1);

        // Bounce: two scans of press then release never produce an event.
        for (int i = 0; i < 2; i++) do_scan(K6, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) do_scan('0, 1'b1, 1'b0);
        do_scan(K6, 1'b1, 1'b0);
        do_scan('0, 1'b1, 1'b0);

        // Consumer stalled: second press is dropped and flags overflow.
        for (int i = 0; i < 3; i++) do_scan(K6, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) do_scan('0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) do_scan(K9, 1'b0, 1'b0);
        do_scan(K9, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) do_scan('0, 1'b0, 1'b0);

        // Two keys together: the lower index wins.
        for (int i = 0; i < 3; i++) do_scan(K3 | K12, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) do_scan('0, 1'b1, 1'b0);

        // Reset in the middle of debouncing key 5.
        for (int i = 0; i < 2; i++) do_scan(K5, 1'b1, 1'b0);
        repeat (13) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_col_n", col_n, 4'b1110);
        check("midrst_key_valid", key_valid, 1'b0);
        check("midrst_key_held", key_held, 1'b0);
        check("midrst_overflow", overflow, 1'b0);
        check("midrst_key_code", key_code, 4'd0);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) do_scan(K5, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) do_scan('0, 1'b1, 1'b0);

        // Randomized key sets and consumer behaviour.
        m = '0;
        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 9);
            if (r < 4) m = m;
            else if (r < 7) m = '0;
            else if (r < 9) m = 16'h0001 << $urandom_range(0, 15);
            else m = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
            r = $urandom_range(0, 3);
            do_scan(m, r != 0, r == 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
